// File: rtl/modbus_rtu_tx_framer_pkg.sv
// Shared Modbus RTU timing definitions: character-time bit counts, state encoding
// and the bit-period prescaler derivation used by both transmit and receive timers.
package modbus_rtu_tx_framer_pkg;

   localparam int unsigned BIT_CNT_W     = 6;
   localparam int unsigned CHAR_1P5_BITS = 15;
   localparam int unsigned CHAR_3P5_BITS = 35;

   typedef enum logic [1:0] {
      ST_GUARD = 2'd0,
      ST_ARMED = 2'd1,
      ST_SEND  = 2'd2,
      ST_GAP   = 2'd3
   } tx_state_e;

   // Clock cycles per bit period; the result must fit the 16-bit prescaler range.
   function automatic int unsigned bpsParam(input int unsigned clkFreq,
                                            input int unsigned baudRate);
      return clkFreq / baudRate;
   endfunction

endpackage

// File: rtl/modbus_bit_tick.sv
// Bit-period prescaler: counts 0..BPS_PARAM-1 and flags the wrap cycle as a bit tick.
// The synchronous clear restarts the bit period from zero.
module modbus_bit_tick #(
   parameter int unsigned BPS_PARAM = 5208
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned     CNT_W = (BPS_PARAM > 1) ? $clog2(BPS_PARAM) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS_PARAM - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/modbus_rtu_tx_framer.sv
// Modbus RTU transmit framer: enforces 3.5-char silence around frames, keeps frame
// bytes back-to-back and aborts a frame when the next byte arrives too late.
module modbus_rtu_tx_framer
   import modbus_rtu_tx_framer_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 50000000,
   parameter int unsigned BAUD_RATE    = 9600,
   parameter int unsigned GUARD_BITS   = CHAR_3P5_BITS,
   parameter int unsigned GAP_MAX_BITS = 10
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [7:0] frame_data,
   input  logic       frame_valid,
   input  logic       frame_last,
   output logic       frame_ready,
   input  logic       rx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       tx_frame_busy,
   output logic       tx_frame_done,
   output logic       tx_underrun
);

   localparam int unsigned          BPS_PARAM  = bpsParam(CLK_FREQ, BAUD_RATE);
   localparam logic [BIT_CNT_W-1:0] GUARD_LAST = BIT_CNT_W'(GUARD_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] GAP_LAST   = BIT_CNT_W'(GAP_MAX_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
   logic [7:0]           data_q, data_d;
   logic                 last_q, last_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 frameDone_q, frameDone_d;
   logic                 underrun_q, underrun_d;
   logic                 tick;
   logic                 clearCnt;
   logic                 accept;

   modbus_bit_tick #(
      .BPS_PARAM(BPS_PARAM)
   ) uBitTick (
      .clk_i  (clk_in),
      .rst_ni (rst_n_in),
      .clear_i(clearCnt),
      .tick_o (tick)
   );

   // frame_ready is the only unregistered output so a byte can be taken the cycle it appears.
   always_comb begin
      frame_ready = 1'b0;
      case (state_q)
         ST_ARMED: frame_ready = !rx_busy;
         ST_GAP:   frame_ready = 1'b1;
         default:  frame_ready = 1'b0;
      endcase
   end

   assign accept = frame_valid && frame_ready;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      last_d      = last_q;
      start_d     = 1'b0;
      frameDone_d = 1'b0;
      underrun_d  = 1'b0;
      clearCnt    = 1'b0;
      case (state_q)
         ST_GUARD: begin
            if (rx_busy) begin
               clearCnt = 1'b1;
            end else if (tick && (bitCnt_q == GUARD_LAST)) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (rx_busy) begin
               state_d  = ST_GUARD;
               clearCnt = 1'b1;
            end
         end
         ST_SEND: begin
            if (tx_done) begin
               clearCnt = 1'b1;
               if (last_q) begin
                  frameDone_d = 1'b1;
                  state_d     = ST_GUARD;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (!accept && tick && (bitCnt_q == GAP_LAST)) begin
               underrun_d = 1'b1;
               state_d    = ST_GUARD;
               clearCnt   = 1'b1;
            end
         end
         default: begin
            state_d  = ST_GUARD;
            clearCnt = 1'b1;
         end
      endcase
      // A late byte that lands on the gap-limit tick still counts as on time.
      if (accept) begin
         data_d  = frame_data;
         last_d  = frame_last;
         start_d = 1'b1;
         state_d = ST_SEND;
      end
   end

   always_comb begin
      bitCnt_d = bitCnt_q;
      if (clearCnt) begin
         bitCnt_d = '0;
      end else if (tick) begin
         bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
      end
      busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_GUARD;
         bitCnt_q    <= '0;
         data_q      <= '0;
         last_q      <= 1'b0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         frameDone_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         data_q      <= data_d;
         last_q      <= last_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         frameDone_q <= frameDone_d;
         underrun_q  <= underrun_d;
      end
   end

   assign tx_start      = start_q;
   assign tx_data       = data_q;
   assign tx_frame_busy = busy_q;
   assign tx_frame_done = frameDone_q;
   assign tx_underrun   = underrun_q;

endmodule

// File: tb/tb_modbus_rtu_tx_framer.sv
// Directed-plus-random bench for the Modbus RTU transmit framer, with a UART
// latency model and expected timing derived from character-time arithmetic.
module tb_modbus_rtu_tx_framer;

   localparam int CLK_FREQ  = 960000;
   localparam int BAUD_RATE = 9600;
   localparam int BPS       = CLK_FREQ / BAUD_RATE;
   localparam int GUARD_CYC = 35 * BPS;
   localparam int GAP_CYC   = 10 * BPS;
   localparam int UART_LAT  = 1000;

   localparam int SEL_DONE  = 0;
   localparam int SEL_UNDER = 1;
   localparam int SEL_READY = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] frame_data;
   logic       frame_valid;
   logic       frame_last;
   logic       frame_ready;
   logic       rx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       tx_frame_busy;
   logic       tx_frame_done;
   logic       tx_underrun;

   int cyc = 0;
   int uartCnt;
   int startCount = 0;
   int underCount = 0;
   int asserts;
   int failures;

   modbus_rtu_tx_framer #(
      .CLK_FREQ    (CLK_FREQ),
      .BAUD_RATE   (BAUD_RATE),
      .GUARD_BITS  (35),
      .GAP_MAX_BITS(10)
   ) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .frame_data   (frame_data),
      .frame_valid  (frame_valid),
      .frame_last   (frame_last),
      .frame_ready  (frame_ready),
      .rx_busy      (rx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done      (tx_done),
      .tx_frame_busy(tx_frame_busy),
      .tx_frame_done(tx_frame_done),
      .tx_underrun  (tx_underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART stand-in: tx_done rises UART_LAT cycles after tx_start rises.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_done <= 1'b0;
         uartCnt <= 0;
      end else begin
         tx_done <= 1'b0;
         if (tx_start) begin
            uartCnt <= 1;
         end else if (uartCnt == UART_LAT - 1) begin
            tx_done <= 1'b1;
            uartCnt <= 0;
         end else if (uartCnt != 0) begin
            uartCnt <= uartCnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (tx_start)    startCount <= startCount + 1;
      if (tx_underrun) underCount <= underCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      asserts++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic waitFor(input int sel, input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if ((sel == SEL_DONE && tx_frame_done) || (sel == SEL_UNDER && tx_underrun) ||
             (sel == SEL_READY && frame_ready)) begin
            ok = 1'b1;
            at = cyc;
         end
      end
   endtask

   // Waits for frame_ready, idles `delay` cycles, then hands the byte over.
   task automatic applyStimulus(input string tag, input logic [7:0] d, input logic lastFlag,
                                input int delay, output int readyAt, output int acceptAt);
      bit seen = 1'b0;
      frame_data  = d;
      frame_last  = lastFlag;
      frame_valid = (delay == 0);
      readyAt     = -1;
      acceptAt    = -1;
      for (int i = 0; i < GUARD_CYC + 2 * GAP_CYC && !seen; i++) begin
         if (frame_ready) begin
            seen    = 1'b1;
            readyAt = cyc;
         end else begin
            @(negedge clk);
         end
      end
      checkOutput({tag, "_ready_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         repeat (delay) @(negedge clk);
         frame_valid = 1'b1;
         @(negedge clk);
         acceptAt    = cyc;
         frame_valid = 1'b0;
         checkOutput({tag, "_accept_time"}, acceptAt - readyAt, delay + 1);
         checkOutput({tag, "_tx_start"}, 32'(tx_start), 32'd1);
         checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'(d));
         checkOutput({tag, "_ready_low"}, 32'(frame_ready), 32'd0);
         checkOutput({tag, "_busy"}, 32'(tx_frame_busy), 32'd1);
      end
      frame_valid = 1'b0;
   endtask

   initial begin
      int rel, rdy, acc, prev, at, fall, sc, len, dly;
      bit ok;
      logic [7:0] b;
      logic [7:0] frame3 [4];
      frame3[0] = 8'h01; frame3[1] = 8'h03; frame3[2] = 8'h00; frame3[3] = 8'h0A;
      asserts = 0;
      failures = 0;
      rst_n = 1'b0;
      rx_busy = 1'b0;
      frame_valid = 1'b1;
      frame_last = 1'b1;
      frame_data = 8'hA5;

      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 32'(frame_ready), 32'd0);
      checkOutput("rst_start", 32'(tx_start), 32'd0);
      checkOutput("rst_data", 32'(tx_data), 32'd0);
      checkOutput("rst_busy", 32'(tx_frame_busy), 32'd0);
      checkOutput("rst_done", 32'(tx_frame_done), 32'd0);
      checkOutput("rst_under", 32'(tx_underrun), 32'd0);

      // 1: guard after reset, single-byte frame
      rst_n = 1'b1;
      rel = cyc;
      b = 8'($urandom);
      applyStimulus("t1", b, 1'b1, 0, rdy, acc);
      checkOutput("t1_guard_len", rdy - rel, GUARD_CYC);
      waitFor(SEL_DONE, UART_LAT + 20, at, ok);
      checkOutput("t1_done_seen", 32'(ok), 32'd1);
      checkOutput("t1_done_time", at - acc, UART_LAT + 1);
      checkOutput("t1_busy_end", 32'(tx_frame_busy), 32'd0);
      @(negedge clk);
      checkOutput("t1_done_pulse", 32'(tx_frame_done), 32'd0);
      at = at;

      // 3: back-to-back 4-byte frame
      fall = at;
      applyStimulus("t3_b0", frame3[0], 1'b0, 0, rdy, acc);
      checkOutput("t3_guard_len", rdy - fall, GUARD_CYC);
      for (int i = 1; i < 4; i++) begin
         prev = acc;
         applyStimulus("t3_bn", frame3[i], (i == 3), 0, rdy, acc);
         checkOutput("t3_gap_ready", rdy - prev, UART_LAT + 1);
         checkOutput("t3_start_spacing", acc - prev, UART_LAT + 2);
      end
      waitFor(SEL_DONE, UART_LAT + 20, at, ok);
      checkOutput("t3_done_time", at - acc, UART_LAT + 1);

      // 2: rx_busy during guard, then a random frame with random gaps
      repeat (2000) @(negedge clk);
      rx_busy = 1'b1;
      repeat ($urandom_range(1, 50)) @(negedge clk);
      checkOutput("t2_ready_busy", 32'(frame_ready), 32'd0);
      rx_busy = 1'b0;
      fall = cyc;
      len = $urandom_range(1, 4);
      applyStimulus("t2_b0", 8'($urandom), (len == 1), 0, rdy, acc);
      checkOutput("t2_guard_len", rdy - fall, GUARD_CYC);
      for (int i = 1; i < len; i++) begin
         prev = acc;
         dly = $urandom_range(0, 900);
         applyStimulus("t2_bn", 8'($urandom), (i == len - 1), dly, rdy, acc);
         checkOutput("t2_gap_ready", rdy - prev, UART_LAT + 1);
      end
      waitFor(SEL_DONE, UART_LAT + 20, at, ok);
      checkOutput("t2_done_time", at - acc, UART_LAT + 1);

      // 4: underrun when the second byte never comes
      fall = at;
      applyStimulus("t4_b0", 8'($urandom), 1'b0, 0, rdy, acc);
      checkOutput("t4_guard_len", rdy - fall, GUARD_CYC);
      waitFor(SEL_READY, UART_LAT + 20, rdy, ok);
      checkOutput("t4_gap_ready", rdy - acc, UART_LAT + 1);
      waitFor(SEL_UNDER, GAP_CYC + 20, at, ok);
      checkOutput("t4_under_seen", 32'(ok), 32'd1);
      checkOutput("t4_under_time", at - rdy, GAP_CYC);
      checkOutput("t4_busy_after", 32'(tx_frame_busy), 32'd0);
      checkOutput("t4_ready_after", 32'(frame_ready), 32'd0);
      sc = startCount;
      fall = at;
      applyStimulus("t4_next", 8'($urandom), 1'b1, 0, rdy, acc);
      checkOutput("t4_guard_len", rdy - fall, GUARD_CYC);
      @(negedge clk);
      checkOutput("t4_start_count", startCount, sc + 1);
      waitFor(SEL_DONE, UART_LAT + 20, at, ok);
      checkOutput("t4_done_seen", 32'(ok), 32'd1);

      // 5: byte lands on the gap-limit tick
      fall = at;
      applyStimulus("t5_b0", 8'($urandom), 1'b0, 0, rdy, acc);
      checkOutput("t5_guard_len", rdy - fall, GUARD_CYC);
      prev = acc;
      applyStimulus("t5_b1", 8'($urandom), 1'b1, GAP_CYC - 1, rdy, acc);
      checkOutput("t5_gap_ready", rdy - prev, UART_LAT + 1);
      checkOutput("t5_no_under", 32'(tx_underrun), 32'd0);
      waitFor(SEL_DONE, UART_LAT + 20, at, ok);
      checkOutput("t5_done_time", at - acc, UART_LAT + 1);
      checkOutput("t5_under_count", underCount, 1);

      // 6: rx_busy wins over frame_valid in ARMED; then reset mid-SEND
      fall = at;
      frame_valid = 1'b0;
      waitFor(SEL_READY, GUARD_CYC + 20, rdy, ok);
      checkOutput("t6_guard_len", rdy - fall, GUARD_CYC);
      b = 8'($urandom);
      frame_data = b;
      frame_last = 1'b1;
      frame_valid = 1'b1;
      rx_busy = 1'b1;
      #1;
      checkOutput("t6_ready_busy", 32'(frame_ready), 32'd0);
      @(negedge clk);
      rx_busy = 1'b0;
      fall = cyc;
      checkOutput("t6_no_start", 32'(tx_start), 32'd0);
      checkOutput("t6_not_busy", 32'(tx_frame_busy), 32'd0);
      applyStimulus("t6_b0", b | 8'h80, 1'b1, 0, rdy, acc);
      checkOutput("t6_guard_len", rdy - fall, GUARD_CYC);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_start", 32'(tx_start), 32'd0);
      checkOutput("t6_rst_data", 32'(tx_data), 32'd0);
      checkOutput("t6_rst_busy", 32'(tx_frame_busy), 32'd0);
      checkOutput("t6_rst_ready", 32'(frame_ready), 32'd0);
      checkOutput("t6_rst_done", 32'(tx_frame_done), 32'd0);
      checkOutput("t6_rst_under", 32'(tx_underrun), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      sc = startCount;
      applyStimulus("t6_after", 8'($urandom), 1'b1, 0, rdy, acc);
      checkOutput("t6_guard_len", rdy - rel, GUARD_CYC);
      @(negedge clk);
      checkOutput("t6_start_count", startCount, sc + 1);
      waitFor(SEL_DONE, UART_LAT + 20, at, ok);
      checkOutput("t6_done_seen", 32'(ok), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
